// File: rtl/greycode_decoder_if.sv
// greycode_decoder_if
// Sample/result bundle between a Gray-code stream source (master) and the
// greycode_decoder monitor (slave). clk and reset are plain module ports.
interface greycode_decoder_if #(
    parameter int WIDTH = 3,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0] gray_in;     // Gray-coded sample
    logic             gray_valid;  // gray_in is sampled this cycle
    logic             clear_err;   // synchronous clear of err_count
    logic [WIDTH-1:0] bin_out;     // registered binary of last sample
    logic             bin_valid;   // pulse: bin_out updated
    logic             step_err;    // pulse: last sample was an illegal step
    logic             locked;      // stream is tracking correctly
    logic [CNT_W-1:0] err_count;   // saturating count of step errors

    modport master (
        output gray_in, gray_valid, clear_err,
        input  bin_out, bin_valid, step_err, locked, err_count
    );

    modport slave (
        input  gray_in, gray_valid, clear_err,
        output bin_out, bin_valid, step_err, locked, err_count
    );
endinterface

// File: rtl/greycode_decoder.sv
// greycode_decoder
// Decodes a WIDTH-bit Gray stream into registered binary and monitors it:
// every valid sample after the first must be the Gray successor (or a
// repeat) of the previous one. LOCK_COUNT consecutive good steps lock the
// monitor; any other step pulses step_err and drops back to acquisition.
// Optional build macro: GREYCODE_DEC_ERRCNT_EN builds the saturating error
// counter and its clear; without it err_count is tied to 0.
module greycode_decoder #(
    parameter int WIDTH      = 3,
    parameter int LOCK_COUNT = 2,
    parameter int CNT_W      = 8
) (
    input  logic              clk,
    input  logic              reset,   // asynchronous, active-low
    greycode_decoder_if.slave bus
);

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_ACQUIRE  = 2'd1,
        ST_LOCKED   = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    localparam logic [3:0]       LC  = 4'(LOCK_COUNT);

    state_t           r_state;
    logic [3:0]       r_good_cnt;
    logic [WIDTH-1:0] r_bin_out;   // also serves as the previous sample
    logic             r_bin_valid;
    logic             r_step_err;
    logic             r_locked;

    logic [WIDTH-1:0] w_bin;
    logic             w_good;
    logic             w_repeat;
    logic             w_err;

    // Gray to binary: each binary bit is the XOR of all Gray bits at or
    // above it, which avoids a bit-serial chain through one vector.
    for (genvar i = 0; i < WIDTH; i++) begin : g_conv
        assign w_bin[i] = ^bus.gray_in[WIDTH-1:i];
    end

    // Wrap from all-ones to zero falls out of the modulo-2^WIDTH add.
    assign w_good   = (w_bin == r_bin_out + ONE);
    assign w_repeat = (w_bin == r_bin_out);
    assign w_err    = bus.gray_valid && (r_state != ST_UNLOCKED) && !w_good && !w_repeat;

    // Lock state machine with registered sample, pulse and lock outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_UNLOCKED;
            r_good_cnt  <= 4'd0;
            r_bin_out   <= '0;
            r_bin_valid <= 1'b0;
            r_step_err  <= 1'b0;
            r_locked    <= 1'b0;
        end else begin
            r_bin_valid <= 1'b0;
            r_step_err  <= 1'b0;
            if (bus.gray_valid) begin
                // Always follow the stream, even on an error, so the
                // checker resynchronises to the new position.
                r_bin_out   <= w_bin;
                r_bin_valid <= 1'b1;
                case (r_state)
                    ST_UNLOCKED: begin
                        r_state    <= ST_ACQUIRE;
                        r_good_cnt <= 4'd0;
                    end
                    ST_ACQUIRE: begin
                        if (w_good) begin
                            r_good_cnt <= r_good_cnt + 4'd1;
                            if (r_good_cnt + 4'd1 >= LC) begin
                                r_state  <= ST_LOCKED;
                                r_locked <= 1'b1;
                            end
                        end else if (!w_repeat) begin
                            r_good_cnt <= 4'd0;
                            r_step_err <= 1'b1;
                        end
                    end
                    ST_LOCKED: begin
                        if (!w_good && !w_repeat) begin
                            r_state    <= ST_ACQUIRE;
                            r_good_cnt <= 4'd0;
                            r_locked   <= 1'b0;
                            r_step_err <= 1'b1;
                        end
                    end
                    default: begin
                        r_state    <= ST_UNLOCKED;
                        r_good_cnt <= 4'd0;
                        r_locked   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.bin_out   = r_bin_out;
    assign bus.bin_valid = r_bin_valid;
    assign bus.step_err  = r_step_err;
    assign bus.locked    = r_locked;

`ifdef GREYCODE_DEC_ERRCNT_EN
    logic [CNT_W-1:0] r_err_count;

    // Saturating step-error counter; a clear in the same cycle as an error wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err_count <= '0;
        end else if (bus.clear_err) begin
            r_err_count <= '0;
        end else if (w_err && (r_err_count != {CNT_W{1'b1}})) begin
            r_err_count <= r_err_count + CNT_W'(1);
        end
    end

    assign bus.err_count = r_err_count;
`else
    logic w_unused_clear;
    logic w_unused_err;

    assign bus.err_count  = '0;
    assign w_unused_clear = bus.clear_err;
    assign w_unused_err   = w_err;
`endif

endmodule

// File: tb/tb_greycode_decoder.sv
// tb_greycode_decoder
// Directed scenarios followed by random traffic, checked against a
// behavioural model of the Gray-stream monitor. Two decoders share the
// stimulus: CNT_W=8 and CNT_W=2 (for error-counter saturation).
module tb_greycode_decoder;
    localparam int W  = 3;
    localparam int LC = 2;
    localparam int M  = 1 << W;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    greycode_decoder_if #(.WIDTH(W), .CNT_W(8)) ifa ();
    greycode_decoder_if #(.WIDTH(W), .CNT_W(2)) ifb ();

    greycode_decoder #(.WIDTH(W), .LOCK_COUNT(LC), .CNT_W(8)) dut_a (
        .clk(clk), .reset(reset), .bus(ifa)
    );
    greycode_decoder #(.WIDTH(W), .LOCK_COUNT(LC), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .bus(ifb)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Behavioural model state
    bit m_started, m_locked, m_bv, m_se;
    int m_prev, m_run, m_bin, m_cnt8, m_cnt2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_started = 0; m_locked = 0; m_bv = 0; m_se = 0;
        m_prev = 0; m_run = 0; m_bin = 0; m_cnt8 = 0; m_cnt2 = 0;
    endtask

    task automatic model_step(input int b, input bit v, input bit clr);
        bit err;
        err = 0;
        if (v) begin
            if (!m_started) begin
                m_started = 1;
                m_run = 0;
            end else if (b == (m_prev + 1) % M) begin
                if (!m_locked) begin
                    m_run++;
                    if (m_run >= LC) m_locked = 1;
                end
            end else if (b != m_prev) begin
                err = 1;
                m_run = 0;
                m_locked = 0;
            end
            m_prev = b;
            m_bin  = b;
            m_bv   = 1;
            m_se   = err;
            if (err) begin
                if (m_cnt8 < 255) m_cnt8++;
                if (m_cnt2 < 3) m_cnt2++;
            end
        end else begin
            m_bv = 0;
            m_se = 0;
        end
        if (clr) begin
            m_cnt8 = 0;
            m_cnt2 = 0;
        end
    endtask

    function automatic int exp_cnt(input int c);
`ifdef GREYCODE_DEC_ERRCNT_EN
        return c;
`else
        return 0 * c;
`endif
    endfunction

    task automatic check_all();
        chk("bin_out",     32'(ifa.bin_out),   32'(m_bin));
        chk("bin_valid",   32'(ifa.bin_valid), 32'(m_bv));
        chk("step_err",    32'(ifa.step_err),  32'(m_se));
        chk("locked",      32'(ifa.locked),    32'(m_locked));
        chk("err_count8",  32'(ifa.err_count), 32'(exp_cnt(m_cnt8)));
        chk("step_err_b",  32'(ifb.step_err),  32'(m_se));
        chk("locked_b",    32'(ifb.locked),    32'(m_locked));
        chk("err_count2",  32'(ifb.err_count), 32'(exp_cnt(m_cnt2)));
    endtask

    // One clock: present binary value b as Gray, then check after the edge.
    task automatic drive(input int b, input bit v, input bit clr);
        logic [W-1:0] g;
        g = W'(b ^ (b >> 1));
        ifa.gray_in = g; ifa.gray_valid = v; ifa.clear_err = clr;
        ifb.gray_in = g; ifb.gray_valid = v; ifb.clear_err = clr;
        @(posedge clk);
        #1;
        model_step(b, v, clr);
        check_all();
    endtask

    task automatic seq(input int b);
        drive(b, 1'b1, 1'b0);
    endtask

    initial begin
        int r, b;
        ifa.gray_in = '0; ifa.gray_valid = 1'b0; ifa.clear_err = 1'b0;
        ifb.gray_in = '0; ifb.gray_valid = 1'b0; ifb.clear_err = 1'b0;
        model_reset();
        #2;
        check_all();                       // reset state
        #20 reset = 1'b1;

        // Lock acquisition: Gray 000, 001, 011
        seq(0); seq(1); seq(2);
        chk("lock_acq", 32'(ifa.locked), 32'd1);

        // Wrap-around in LOCKED: bins 6, 7, 0
        seq(3); seq(4); seq(5); seq(6); seq(7); seq(0);
        chk("wrap_bin", 32'(ifa.bin_out), 32'd0);
        chk("wrap_lock", 32'(ifa.locked), 32'd1);

        // Step error at bin 2 -> bin 4, then relock on 5, 6
        seq(1); seq(2); seq(4);
        chk("err_pulse", 32'(ifa.step_err), 32'd1);
        chk("err_unlock", 32'(ifa.locked), 32'd0);
        seq(5); seq(6);
        chk("relock", 32'(ifa.locked), 32'd1);

        // Repeat and gaps: bin 3 twice, 3 idle cycles, then bin 4
        seq(7); seq(0); seq(1); seq(2);
        seq(3); seq(3);
        drive(3, 1'b0, 1'b0); drive(3, 1'b0, 1'b0); drive(3, 1'b0, 1'b0);
        seq(4);
        chk("gap_lock", 32'(ifa.locked), 32'd1);

        // Saturation: 5 errors, then clear together with a 6th
        seq(0); seq(4); seq(0); seq(4); seq(0);
        drive(4, 1'b1, 1'b1);
        chk("clr_err_pulse", 32'(ifb.step_err), 32'd1);
        chk("clr_wins", 32'(ifb.err_count), 32'd0);

        // Mid-stream reset while locked
        seq(5); seq(6); seq(7);
        reset = 1'b0;
        #1;
        model_reset();
        check_all();
        #10 reset = 1'b1;
        seq(3);                            // first sample after release
        chk("post_rst_err", 32'(ifa.step_err), 32'd0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 19);
            if (r < 11)       drive((m_prev + 1) % M, 1'b1, 1'b0);
            else if (r < 13)  drive(m_prev, 1'b1, 1'b0);
            else if (r < 16)  begin b = $urandom_range(0, M - 1); drive(b, 1'b1, 1'b0); end
            else if (r < 18)  drive(m_prev, 1'b0, 1'b0);
            else if (r < 19)  begin b = $urandom_range(0, M - 1); drive(b, 1'b1, 1'b1); end
            else              drive((m_prev + 1) % M, 1'b0, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/greycode_decoder.md
# greycode_decoder

- Receiving end of the greycode counter interface: samples a WIDTH-bit Gray-coded stream and converts it to registered binary.
- Checks that every new sample is the Gray successor of the previous one, and reports lock and step errors.
- Sits beside the greycode counter (or across a clock-domain-crossing synchronizer from it) as its decoder/monitor.

## Interface
- WIDTH, 3, Gray/binary word width (≥2)
- LOCK_COUNT, 2, consecutive good steps required to assert lock (1..15)
- CNT_W, 8, width of the error counter
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- gray_in  input  WIDTH  Gray-coded sample
- gray_valid  input  1  gray_in is sampled this cycle
- clear_err  input  1  synchronous clear of err_count
- bin_out  output  WIDTH  registered binary of last sampled gray_in
- bin_valid  output  1  one-cycle pulse: bin_out updated
- step_err  output  1  one-cycle pulse: last sample was an illegal step
- locked  output  1  stream is tracking correctly
- err_count  output  CNT_W  saturating count of step errors

## Operation
- Conversion: b[WIDTH-1]=g[WIDTH-1]; b[i]=b[i+1]^g[i] for i below the MSB. The result is registered into bin_out on every valid sample.
- Step classification, applied to each valid sample after the first, with prev = last sampled binary value:
  - good: new == (prev+1) mod 2^WIDTH. The wrap 2^WIDTH−1 → 0 (Gray 100 → 000 for WIDTH=3) is good.
  - repeat: new == prev. Neither good nor error. good_cnt and state are held.
  - error: any other value.
- The state machine has three states: UNLOCKED, ACQUIRE and LOCKED.
  - UNLOCKED: the first valid sample loads prev and moves to ACQUIRE with good_cnt=0. No check is made on this sample.
  - ACQUIRE, good step: good_cnt+1. When good_cnt reaches LOCK_COUNT, move to LOCKED.
  - ACQUIRE, error: good_cnt=0, step_err pulses, stay in ACQUIRE.
  - LOCKED, good or repeat step: stay in LOCKED.
  - LOCKED, error: move to ACQUIRE, good_cnt=0, step_err pulses.
- prev is updated on every valid sample, including error samples, so the checker resynchronises to the new position.
- locked = (state == LOCKED), registered.
- Cycles with gray_valid=0 change nothing except clearing the bin_valid and step_err pulses.

## Timing
- Reset (async, active-low): bin_out=0, bin_valid=0, step_err=0, locked=0, err_count=0, state=UNLOCKED, good_cnt=0, prev=0.
- Latency is 1 cycle:
  - A sample at edge N appears on bin_out, bin_valid and step_err after edge N.
  - locked rises (or falls) after the same edge as the sample that caused the transition.
- Back-to-back samples are accepted every cycle; there is no backpressure.
- clear_err and a step error in the same cycle: clear wins, err_count=0.
- err_count saturates at 2^CNT_W−1; a further error still pulses step_err.
- Reset asserted mid-stream: all outputs drop asynchronously. After release, the next valid sample is treated as the first sample (UNLOCKED path), with no error.

## Configuration
- GREYCODE_DEC_ERRCNT_EN
  - Defined: err_count and clear_err logic are present as described.
  - Undefined: the counter is not built, err_count is tied to 0 and clear_err is ignored. step_err and locked behave identically in both builds.

## Test plan
All scenarios use WIDTH=3, LOCK_COUNT=2, CNT_W=8 unless noted.
- Lock acquisition: reset low 20 ns then high; drive valid Gray 000, 001, 011 on consecutive cycles.
  - Required: bin_out shows 0, 1, 2.
  - Required: locked=1 after the third sample's edge; step_err stays 0.
- Wrap-around: in LOCKED, drive 101, 100, 000 (bins 6, 7, 0).
  - Required: no step_err, locked stays 1, bin_out reaches 0.
- Step error: in LOCKED at bin 2 (Gray 011), drive 110 (bin 4).
  - Required: step_err pulses one cycle, locked → 0, err_count=1.
  - Then drive 111, 101 (bins 5, 6). Required: locked=1 again.
- Repeat and gaps: in LOCKED, drive 010 twice, then gray_valid=0 for 3 cycles, then 110.
  - Required: no error, locked stays 1, bin_valid pulses only on the valid cycles.
- Saturation and clear (CNT_W=2): inject 5 errors.
  - Required: err_count=3.
  - Assert clear_err together with a 6th error. Required: err_count=0, step_err=1.
- Mid-stream reset and build variant:
  - Assert reset while locked. Required: all outputs 0 immediately.
  - The first sample after release gives step_err=0.
  - With GREYCODE_DEC_ERRCNT_EN undefined, rerun the step-error scenario. Required: err_count stays 0.
